// File: rtl/seq_pkg.sv
// Shared definitions for the seq101 serial transmitter.
// Holds the transmitter FSM encoding, the "101" detector state encoding, and
// the default frame geometry used by seq101_tx.
package seq_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } tx_state_e;

  // S0: nothing useful seen, S1: "1", S2: "10", S3: "101" (match)
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_e;

endpackage

// File: rtl/seq101_det.sv
// Overlapping "101" Moore detector.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset (returns to S0)
//   clr    - synchronous clear to S0, takes priority over en
//   en     - advance on bit_in this cycle
//   bit_in - serial bit under observation
//   hit    - high while in S3, i.e. the last three observed bits were "101"
module seq101_det
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic hit
);

  det_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S0;
    end else if (en) begin
      case (state_q)
        S0:      state_d = bit_in ? S1 : S0;
        S1:      state_d = bit_in ? S1 : S2;
        S2:      state_d = bit_in ? S3 : S0;
        // After a match the trailing "1" is reused, giving overlap.
        S3:      state_d = bit_in ? S1 : S2;
        default: state_d = S0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign hit = (state_q == S3);

endmodule

// File: rtl/seq101_tx.sv
// Serial frame transmitter with an overlapping "101" counter on the output.
// A frame of len bits (the low len bits of data, MSB first) is shifted out
// one bit per cycle, followed by a single-cycle done pulse.
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   start     - frame request, only honoured in IDLE
//   data, len - payload and bit count, captured on the accepting edge
//   dout      - serial bit (0 when dvalid is low)
//   dvalid    - dout carries a frame bit
//   busy      - frame is being shifted
//   done      - one-cycle pulse after the last bit
//   match_cnt - "101" occurrences in the current/last frame
module seq101_tx
  import seq_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] data,
  input  logic [LEN_W-1:0]  len,
  output logic              dout,
  output logic              dvalid,
  output logic              busy,
  output logic              done,
  output logic [2:0]        match_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WORD_W);

  tx_state_e         state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        mcnt_q, mcnt_d;
  logic [LEN_W-1:0]  len_c;
  logic              accept;
  logic              det_en;
  logic              det_hit;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic inc);
    if (inc && (v != 3'd7)) return v + 3'd1;
    return v;
  endfunction

  assign len_c  = clamp_len(len);
  assign det_en = (state_q == ST_SHIFT);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    mcnt_d  = mcnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          // Left-justify the selected field so the MSB of the frame is sr[MSB].
          sr_d    = data << (WORD_W - int'(len_c));
          cnt_d   = len_c;
          mcnt_d  = '0;
          state_d = (len_c == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d   = sr_q << 1;
        cnt_d  = cnt_q - LEN_W'(1);
        // The detector is Moore, so a match shows up one cycle after its
        // final bit; it is folded into the count on the following edge.
        mcnt_d = sat_inc(mcnt_q, det_hit);
        if (cnt_q == LEN_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        mcnt_d  = sat_inc(mcnt_q, det_hit);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

  seq101_det u_det (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (det_en),
    .bit_in (sr_q[WORD_W-1]),
    .hit    (det_hit)
  );

  assign busy   = (state_q == ST_SHIFT);
  assign dvalid = busy;
  assign dout   = busy & sr_q[WORD_W-1];
  assign done   = (state_q == ST_DONE);
  // A pending detector hit (not yet folded into mcnt_q) is added here so a
  // match completed by the last bit is already visible in the DONE cycle.
  // In IDLE the detector may still sit in S3, but that hit is already counted.
  assign match_cnt = (state_q != ST_IDLE) ? sat_inc(mcnt_q, det_hit) : mcnt_q;

endmodule
